// File: rtl/fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_unit_pkg;

    localparam int unsigned DefLen      = 32;
    localparam logic [31:0] NopWord     = 32'h0000_0000;
    localparam logic [31:0] DefHaltWord = 32'hFFFF_FFFF;
    // A bubble is a NOP with valid low and zeroed pc/adder fields.
    localparam logic [31:0] BubbleWord  = NopWord;

    typedef enum logic {
        StRun    = 1'b0,
        StHalted = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_imem_dp.sv
// Instruction memory: asynchronous read, synchronous write for program loading.
module fetch_unit_imem_dp #(
    parameter int unsigned LEN       = 32,
    parameter int unsigned ADDR_W    = 11,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [LEN-1:0]    wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [LEN-1:0]    rdata_o
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [LEN-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read sees the pre-edge contents, so a same-cycle write returns the old word.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC, redirect/stall/freeze control, halt detection
// and the IF/ID pipeline register around a loadable instruction memory.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned    LEN       = DefLen,
    parameter int unsigned    ADDR_W    = 11,
    parameter int unsigned    PC_STEP   = 1,
    parameter logic [LEN-1:0] HALT_WORD = LEN'(DefHaltWord),
    parameter string          INIT_FILE = ""
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_stall,
    input  logic              i_PCSrc,
    input  logic [LEN-1:0]    i_branch_dir,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [LEN-1:0]    i_wr_data,
    output logic [LEN-1:0]    o_instruccion,
    output logic [LEN-1:0]    o_adder,
    output logic [LEN-1:0]    o_pc,
    output logic              o_valid,
    output logic              o_halt
);

    logic [LEN-1:0] pc_q, pc_d, pc_plus;
    logic [LEN-1:0] instr_q, instr_d;
    logic [LEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [LEN-1:0] adder_q, adder_d;
    logic           valid_q, valid_d;
    fetch_state_e   state_q, state_d;
    logic [LEN-1:0] fetched;

    fetch_unit_imem_dp #(
        .LEN       (LEN),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_imem (
        .clk_i   (i_clk),
        .we_i    (i_wr_en),
        .waddr_i (i_wr_addr),
        .wdata_i (i_wr_data),
        .raddr_i (pc_q[ADDR_W-1:0]),
        .rdata_o (fetched)
    );

    // Wraps modulo 2**LEN.
    assign pc_plus = pc_q + LEN'(PC_STEP);

    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        ifid_pc_d = ifid_pc_q;
        adder_d   = adder_q;
        valid_d   = valid_q;
        state_d   = state_q;

        if (i_enable) begin
            if (i_PCSrc) begin
                pc_d      = i_branch_dir;
                instr_d   = LEN'(BubbleWord);
                ifid_pc_d = '0;
                adder_d   = '0;
                valid_d   = 1'b0;
                state_d   = StRun;
            end else if (!i_stall) begin
                unique case (state_q)
                    StRun: begin
                        instr_d   = fetched;
                        ifid_pc_d = pc_q;
                        adder_d   = pc_plus;
                        valid_d   = 1'b1;
                        // The halt word still reaches decode; only the PC stops.
                        if (fetched == HALT_WORD) begin
                            state_d = StHalted;
                        end else begin
                            pc_d = pc_plus;
                        end
                    end
                    StHalted: begin
                        instr_d   = LEN'(BubbleWord);
                        ifid_pc_d = '0;
                        adder_d   = '0;
                        valid_d   = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            pc_q      <= '0;
            instr_q   <= LEN'(BubbleWord);
            ifid_pc_q <= '0;
            adder_q   <= '0;
            valid_q   <= 1'b0;
            state_q   <= StRun;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            ifid_pc_q <= ifid_pc_d;
            adder_q   <= adder_d;
            valid_q   <= valid_d;
            state_q   <= state_d;
        end
    end

    assign o_instruccion = instr_q;
    assign o_adder       = adder_q;
    assign o_pc          = ifid_pc_q;
    assign o_valid       = valid_q;
    assign o_halt        = (state_q == StHalted);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: word-addressed instance plus a small
// byte-addressed instance for PC and memory-address wrap.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] adder;
        logic        valid;
        logic        halt;
    } ifid_t;

    localparam logic [31:0] Halt = 32'hFFFF_FFFF;
    localparam ifid_t Bubble = '{32'h0, 32'h0, 32'h0, 1'b0, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed instance.
    logic        i_rst = 1'b0, i_enable = 1'b1, i_stall = 1'b0, i_PCSrc = 1'b0;
    logic [31:0] i_branch_dir = '0;
    logic        i_wr_en = 1'b0;
    logic [10:0] i_wr_addr = '0;
    logic [31:0] i_wr_data = '0;
    logic [31:0] o_instruccion, o_adder, o_pc;
    logic        o_valid, o_halt;

    // Byte-addressed, 16-word instance.
    logic        r2_rst = 1'b0, r2_pcsrc = 1'b0, r2_wr_en = 1'b0;
    logic [31:0] r2_dir = '0, r2_wr_data = '0;
    logic [3:0]  r2_wr_addr = '0;
    logic [31:0] o2_instr, o2_adder, o2_pc;
    logic        o2_valid, o2_halt;

    fetch_unit dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_enable      (i_enable),
        .i_stall       (i_stall),
        .i_PCSrc       (i_PCSrc),
        .i_branch_dir  (i_branch_dir),
        .i_wr_en       (i_wr_en),
        .i_wr_addr     (i_wr_addr),
        .i_wr_data     (i_wr_data),
        .o_instruccion (o_instruccion),
        .o_adder       (o_adder),
        .o_pc          (o_pc),
        .o_valid       (o_valid),
        .o_halt        (o_halt)
    );

    fetch_unit #(
        .ADDR_W  (4),
        .PC_STEP (4)
    ) dut2 (
        .i_clk         (clk),
        .i_rst         (r2_rst),
        .i_enable      (1'b1),
        .i_stall       (1'b0),
        .i_PCSrc       (r2_pcsrc),
        .i_branch_dir  (r2_dir),
        .i_wr_en       (r2_wr_en),
        .i_wr_addr     (r2_wr_addr),
        .i_wr_data     (r2_wr_data),
        .o_instruccion (o2_instr),
        .o_adder       (o2_adder),
        .o_pc          (o2_pc),
        .o_valid       (o2_valid),
        .o_halt        (o2_halt)
    );

    ifid_t obs, obs2;
    assign obs  = {o_instruccion, o_pc, o_adder, o_valid, o_halt};
    assign obs2 = {o2_instr, o2_pc, o2_adder, o2_valid, o2_halt};

    ifid_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] addr [7] = '{11'h0, 11'h1, 11'h2, 11'h3, 11'h10, 11'h11, 11'h13};
        logic [31:0] data [7] = '{32'h11, 32'h22, 32'h33, Halt, 32'hAA, 32'hBB, 32'h44};
        ifid_t e;
        i_rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            i_wr_en = 1'b1; i_wr_addr = addr[i]; i_wr_data = data[i];
            tick();
        end
        i_wr_en = 1'b0;
        sb.push_back(Bubble);
        tick();
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset: got %h want %h", obs, e);
        end
    endtask

    task automatic test_fetch_halt();
        ifid_t want [6] = '{
            '{32'h11, 32'd0, 32'd1, 1'b1, 1'b0},
            '{32'h22, 32'd1, 32'd2, 1'b1, 1'b0},
            '{32'h33, 32'd2, 32'd3, 1'b1, 1'b0},
            '{Halt,   32'd3, 32'd4, 1'b1, 1'b1},
            '{32'h0,  32'd0, 32'd0, 1'b0, 1'b1},
            '{32'h0,  32'd0, 32'd0, 1'b0, 1'b1}};
        ifid_t e;
        i_rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sb.push_back(want[i]);
            tick();
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL fetch_halt[%0d]: got %h want %h", i, obs, e);
            end
        end
    endtask

    task automatic test_halt_redirect();
        ifid_t want [3] = '{
            Bubble,
            '{32'h11, 32'd0, 32'd1, 1'b1, 1'b0},
            '{32'h22, 32'd1, 32'd2, 1'b1, 1'b0}};
        ifid_t e;
        for (int i = 0; i < 3; i++) begin
            i_PCSrc = (i == 0); i_branch_dir = 32'h0;
            sb.push_back(want[i]);
            tick();
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL halt_redirect[%0d]: got %h want %h", i, obs, e);
            end
        end
        i_PCSrc = 1'b0;
    endtask

    task automatic test_stall();
        ifid_t want [3] = '{
            '{32'h22, 32'd1, 32'd2, 1'b1, 1'b0},
            '{32'h22, 32'd1, 32'd2, 1'b1, 1'b0},
            '{32'h33, 32'd2, 32'd3, 1'b1, 1'b0}};
        ifid_t e;
        for (int i = 0; i < 3; i++) begin
            i_stall = (i < 2);
            sb.push_back(want[i]);
            tick();
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL stall[%0d]: got %h want %h", i, obs, e);
            end
        end
        i_stall = 1'b0;
    endtask

    task automatic test_redirect_over_stall();
        ifid_t want [3] = '{
            Bubble,
            '{32'hAA, 32'h10, 32'h11, 1'b1, 1'b0},
            '{32'hBB, 32'h11, 32'h12, 1'b1, 1'b0}};
        ifid_t e;
        for (int i = 0; i < 3; i++) begin
            i_PCSrc = (i == 0); i_stall = (i == 0); i_branch_dir = 32'h10;
            sb.push_back(want[i]);
            tick();
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL redirect_stall[%0d]: got %h want %h", i, obs, e);
            end
        end
        i_PCSrc = 1'b0; i_stall = 1'b0;
    endtask

    // Freeze with a write underneath, then a same-edge write/read of one address.
    task automatic test_enable_freeze();
        ifid_t want [7] = '{
            '{32'hBB, 32'h11, 32'h12, 1'b1, 1'b0},
            '{32'hBB, 32'h11, 32'h12, 1'b1, 1'b0},
            '{32'hBB, 32'h11, 32'h12, 1'b1, 1'b0},
            '{32'hCC, 32'h12, 32'h13, 1'b1, 1'b0},
            '{32'h44, 32'h13, 32'h14, 1'b1, 1'b0},
            Bubble,
            '{32'hDD, 32'h13, 32'h14, 1'b1, 1'b0}};
        ifid_t e;
        for (int i = 0; i < 7; i++) begin
            i_enable  = (i >= 3);
            i_wr_en   = (i == 0) || (i == 4);
            i_wr_addr = (i == 0) ? 11'h12 : 11'h13;
            i_wr_data = (i == 0) ? 32'hCC : 32'hDD;
            i_PCSrc   = (i == 5); i_branch_dir = 32'h13;
            sb.push_back(want[i]);
            tick();
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL enable_freeze[%0d]: got %h want %h", i, obs, e);
            end
        end
        i_enable = 1'b1; i_wr_en = 1'b0; i_PCSrc = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        ifid_t want [3] = '{
            Bubble,
            '{32'h11, 32'd0, 32'd1, 1'b1, 1'b0},
            '{32'h22, 32'd1, 32'd2, 1'b1, 1'b0}};
        ifid_t e;
        for (int i = 0; i < 3; i++) begin
            i_rst = (i != 0); i_enable = (i != 0); i_stall = (i == 0);
            sb.push_back(want[i]);
            tick();
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_mid_run[%0d]: got %h want %h", i, obs, e);
            end
        end
    endtask

    task automatic test_wrap();
        ifid_t want [7] = '{
            Bubble,
            Bubble,
            '{32'h5C, 32'h3C, 32'h40, 1'b1, 1'b0},
            '{32'h50, 32'h40, 32'h44, 1'b1, 1'b0},
            Bubble,
            '{32'h5C, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0},
            '{32'h50, 32'h0, 32'h4, 1'b1, 1'b0}};
        ifid_t e;
        r2_rst = 1'b0;
        r2_wr_en = 1'b1; r2_wr_addr = 4'hC; r2_wr_data = 32'h5C;
        tick();
        r2_wr_addr = 4'h0; r2_wr_data = 32'h50;
        for (int i = 0; i < 7; i++) begin
            r2_rst   = (i != 0);
            r2_wr_en = (i == 0);
            r2_pcsrc = (i == 1) || (i == 4);
            r2_dir   = (i == 1) ? 32'h3C : 32'hFFFF_FFFC;
            sb.push_back(want[i]);
            tick();
            e = sb.pop_front();
            n_checks++;
            if (obs2 !== e) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got %h want %h", i, obs2, e);
            end
        end
        r2_pcsrc = 1'b0; r2_rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch_halt();
        test_halt_redirect();
        test_stall();
        test_redirect_over_stall();
        test_enable_freeze();
        test_reset_mid_run();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
